// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared opcode, state and command-field definitions for the SRAM DPU
package sram_pkg;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_NOT   = 2'b01,
        OP_ROTL8 = 2'b10,
        OP_ACC   = 2'b11
    } dpu_op_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'b00,
        D_ARMED  = 2'b01,
        D_CALC   = 2'b10,
        D_COMMIT = 2'b11
    } dpu_state_t;

    localparam int CMD_W        = 8;
    localparam int CMD_VLD_BIT  = 7;
    localparam int CMD_OP_MSB   = 6;
    localparam int CMD_OP_LSB   = 5;
    localparam int CMD_ADDR_MSB = 4;
    localparam int CMD_ADDR_LSB = 0;

    function automatic logic cmd_is_dpu(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_VLD_BIT];
    endfunction

endpackage

// File: rtl/sram_dpu_if.sv
// rtl/sram_dpu_if.sv - controller <-> DPU command/operand/result bundle
interface sram_dpu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              dpu_load_cmd;
    logic [7:0]        nxt_cmd;
    logic              requst_valid;
    logic [DATA_W-1:0] sram_data_to_dpu;
    logic [DATA_W-1:0] sram_data_from_dpu;
    logic [ADDR_W-1:0] sram_addr_from_dpu;
    logic              dpu_busy;
    logic              dpu_done;
    logic              dpu_err;

    modport master (
        output dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
        input  sram_data_from_dpu, sram_addr_from_dpu, dpu_busy, dpu_done, dpu_err
    );

    modport slave (
        input  dpu_load_cmd, nxt_cmd, requst_valid, sram_data_to_dpu,
        output sram_data_from_dpu, sram_addr_from_dpu, dpu_busy, dpu_done, dpu_err
    );
endinterface

// File: rtl/sram_dpu_alu.sv
// rtl/sram_dpu_alu.sv - single-word DPU operation; opcode 11 is ACC under DPU_ACC_EN, else PASS
module sram_dpu_alu
    import sram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int INC_STEP = 1
) (
    input  dpu_op_t           op,
    input  logic [DATA_W-1:0] operand,
`ifdef DPU_ACC_EN
    input  logic [DATA_W-1:0] acc,
`endif
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = operand;
        case (op)
            OP_INC:   result = operand + DATA_W'(INC_STEP);
            OP_NOT:   result = ~operand;
            OP_ROTL8: result = {operand[DATA_W-9:0], operand[DATA_W-1:DATA_W-8]};
`ifdef DPU_ACC_EN
            OP_ACC:   result = acc + operand;
`else
            OP_ACC:   result = operand;
`endif
            default:  result = operand;
        endcase
    end

endmodule

// File: rtl/sram_dpu.sv
// rtl/sram_dpu.sv - DPU sequencer and registers; DPU_ACC_EN builds the persistent accumulator
module sram_dpu
    import sram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int INC_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    sram_dpu_if.slave  bus
);

    dpu_state_t        state;
    dpu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_res;
    logic              done_q;
    logic              err_q;
    logic              cmd_hit;

    assign cmd_hit = bus.dpu_load_cmd && cmd_is_dpu(bus.nxt_cmd);

`ifdef DPU_ACC_EN
    logic [DATA_W-1:0] acc_q;

    sram_dpu_alu #(.DATA_W(DATA_W), .INC_STEP(INC_STEP)) u_alu (
        .op      (op_q),
        .operand (operand_q),
        .acc     (acc_q),
        .result  (alu_res)
    );
`else
    sram_dpu_alu #(.DATA_W(DATA_W), .INC_STEP(INC_STEP)) u_alu (
        .op      (op_q),
        .operand (operand_q),
        .result  (alu_res)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= D_IDLE;
            op_q      <= OP_INC;
            addr_q    <= '0;
            operand_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef DPU_ACC_EN
            acc_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            // Out-of-order strobes are dropped but latched as a sticky error.
            if (cmd_hit && state != D_IDLE)
                err_q <= 1'b1;
            if (bus.requst_valid && (state == D_IDLE || state == D_CALC))
                err_q <= 1'b1;

            case (state)
                D_IDLE: begin
                    if (cmd_hit) begin
                        op_q   <= dpu_op_t'(bus.nxt_cmd[CMD_OP_MSB:CMD_OP_LSB]);
                        addr_q <= ADDR_W'(bus.nxt_cmd[CMD_ADDR_MSB:CMD_ADDR_LSB]);
                        state  <= D_ARMED;
                    end
                end
                D_ARMED: begin
                    if (bus.requst_valid) begin
                        operand_q <= bus.sram_data_to_dpu;
                        state     <= D_CALC;
                    end
                end
                D_CALC: begin
                    result_q <= alu_res;
`ifdef DPU_ACC_EN
                    if (op_q == OP_ACC)
                        acc_q <= alu_res;
`endif
                    state <= D_COMMIT;
                end
                D_COMMIT: begin
                    if (bus.requst_valid) begin
                        done_q <= 1'b1;
                        state  <= D_IDLE;
                    end
                end
                default: state <= D_IDLE;
            endcase
        end
    end

    assign bus.sram_data_from_dpu = result_q;
    assign bus.sram_addr_from_dpu = addr_q;
    assign bus.dpu_busy           = (state != D_IDLE);
    assign bus.dpu_done           = done_q;
    assign bus.dpu_err            = err_q;

endmodule

// File: tb/tb_sram_dpu.sv
// tb/tb_sram_dpu.sv - directed self-checking bench for sram_dpu (both DPU_ACC_EN builds)
module tb_sram_dpu;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sram_dpu_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    sram_dpu #(.DATA_W(32), .ADDR_W(5), .INC_STEP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Starts at a negedge in T0; ends at a negedge in T7 (plus gaps).
    task automatic do_op(input logic [7:0] cmd, input logic [31:0] opnd, input int gap,
                         input logic [31:0] exp_res, input string tag);
        logic [31:0] exp_addr;
        exp_addr = {27'd0, cmd[4:0]};
        bus.dpu_load_cmd = 1'b1;
        bus.nxt_cmd      = cmd;
        step();
        bus.dpu_load_cmd = 1'b0;
        bus.nxt_cmd      = 8'h00;
        chk({tag, " addr_t1"}, bus.sram_addr_from_dpu, exp_addr);
        chk({tag, " busy_t1"}, bus.dpu_busy, 1);
        for (int i = 0; i < 2 + gap; i++) begin
            step();
            chk({tag, " busy_armed"}, bus.dpu_busy, 1);
        end
        bus.requst_valid     = 1'b1;
        bus.sram_data_to_dpu = opnd;
        step();
        bus.requst_valid     = 1'b0;
        bus.sram_data_to_dpu = 32'h0;
        chk({tag, " busy_calc"}, bus.dpu_busy, 1);
        for (int i = 0; i < 1 + gap; i++) begin
            step();
            chk({tag, " done_wait"}, bus.dpu_done, 0);
        end
        chk({tag, " result_t5"}, bus.sram_data_from_dpu, exp_res);
        chk({tag, " addr_t5"}, bus.sram_addr_from_dpu, exp_addr);
        chk({tag, " busy_t5"}, bus.dpu_busy, 1);
        bus.requst_valid = 1'b1;
        step();
        bus.requst_valid = 1'b0;
        chk({tag, " done_t6"}, bus.dpu_done, 1);
        chk({tag, " busy_t6"}, bus.dpu_busy, 0);
        chk({tag, " result_hold"}, bus.sram_data_from_dpu, exp_res);
        step();
        chk({tag, " done_t7"}, bus.dpu_done, 0);
        chk({tag, " addr_hold"}, bus.sram_addr_from_dpu, exp_addr);
    endtask

    initial begin
        n_checks             = 0;
        n_fail               = 0;
        rst_n                = 1'b0;
        bus.dpu_load_cmd     = 1'b0;
        bus.nxt_cmd          = 8'h00;
        bus.requst_valid     = 1'b0;
        bus.sram_data_to_dpu = 32'h0;
        step();
        step();
        chk("rst data", bus.sram_data_from_dpu, 0);
        chk("rst addr", bus.sram_addr_from_dpu, 0);
        chk("rst busy", bus.dpu_busy, 0);
        chk("rst done", bus.dpu_done, 0);
        chk("rst err", bus.dpu_err, 0);
        rst_n = 1'b1;
        step();

        // Strobe without the DPU marker bit is ignored silently.
        bus.dpu_load_cmd = 1'b1;
        bus.nxt_cmd      = 8'h05;
        step();
        bus.dpu_load_cmd = 1'b0;
        bus.nxt_cmd      = 8'h00;
        chk("nodpu busy", bus.dpu_busy, 0);
        chk("nodpu addr", bus.sram_addr_from_dpu, 0);
        chk("nodpu err", bus.dpu_err, 0);

        do_op(8'h83, 32'h0000_00FF, 0, 32'h0000_0100, "inc");
        chk("inc err", bus.dpu_err, 0);
        do_op(8'hBF, 32'hA5A5_0000, 0, 32'h5A5A_FFFF, "not");
        do_op(8'h80, 32'hFFFF_FFFF, 0, 32'h0000_0000, "inc_wrap");
        do_op(8'hC2, 32'h1122_3344, 0, 32'h2233_4411, "rotl8");
`ifdef DPU_ACC_EN
        do_op(8'hE0, 32'd5, 0, 32'd5, "acc1");
        do_op(8'hE0, 32'd7, 0, 32'd12, "acc2");
`else
        do_op(8'hE0, 32'd5, 0, 32'd5, "pass1");
        do_op(8'hE0, 32'd7, 0, 32'd7, "pass2");
`endif
        do_op(8'h8A, 32'h1234_5678, 10, 32'h1234_5679, "stall_inc");
        do_op(8'hA5, 32'h0000_0000, 10, 32'hFFFF_FFFF, "stall_not");
        chk("clean err", bus.dpu_err, 0);

        // Reset while waiting for the commit strobe.
        bus.dpu_load_cmd = 1'b1;
        bus.nxt_cmd      = 8'h84;
        step();
        bus.dpu_load_cmd = 1'b0;
        step();
        step();
        bus.requst_valid     = 1'b1;
        bus.sram_data_to_dpu = 32'h0000_0041;
        step();
        bus.requst_valid = 1'b0;
        step();
        chk("pre_rst result", bus.sram_data_from_dpu, 32'h0000_0042);
        rst_n = 1'b0;
        #1;
        chk("midrst data", bus.sram_data_from_dpu, 0);
        chk("midrst addr", bus.sram_addr_from_dpu, 0);
        chk("midrst busy", bus.dpu_busy, 0);
        chk("midrst done", bus.dpu_done, 0);
        chk("midrst err", bus.dpu_err, 0);
        step();
        rst_n = 1'b1;
        step();
        do_op(8'h86, 32'h0000_0010, 0, 32'h0000_0011, "post_rst");
        chk("post_rst err", bus.dpu_err, 0);

        // requst_valid while idle.
        bus.requst_valid = 1'b1;
        step();
        bus.requst_valid = 1'b0;
        step();
        chk("idle_rv err", bus.dpu_err, 1);
        chk("idle_rv busy", bus.dpu_busy, 0);
        chk("idle_rv addr", bus.sram_addr_from_dpu, 6);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst2 err", bus.dpu_err, 0);

        // Second command while armed must not move the address.
        bus.dpu_load_cmd = 1'b1;
        bus.nxt_cmd      = 8'h83;
        step();
        bus.nxt_cmd = 8'h81;
        step();
        bus.dpu_load_cmd = 1'b0;
        bus.nxt_cmd      = 8'h00;
        chk("armed_cmd addr", bus.sram_addr_from_dpu, 3);
        chk("armed_cmd err", bus.dpu_err, 1);
        chk("armed_cmd busy", bus.dpu_busy, 1);
        step();
        bus.requst_valid     = 1'b1;
        bus.sram_data_to_dpu = 32'h0000_0041;
        step();
        bus.requst_valid = 1'b0;
        step();
        chk("armed_cmd result", bus.sram_data_from_dpu, 32'h0000_0042);
        bus.requst_valid = 1'b1;
        step();
        bus.requst_valid = 1'b0;
        chk("armed_cmd done", bus.dpu_done, 1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Command and requst_valid together in idle: command wins, strobe is an error.
        bus.dpu_load_cmd = 1'b1;
        bus.nxt_cmd      = 8'h84;
        bus.requst_valid = 1'b1;
        step();
        bus.dpu_load_cmd = 1'b0;
        bus.nxt_cmd      = 8'h00;
        bus.requst_valid = 1'b0;
        chk("same_cyc err", bus.dpu_err, 1);
        chk("same_cyc busy", bus.dpu_busy, 1);
        chk("same_cyc addr", bus.sram_addr_from_dpu, 4);
        step();
        chk("same_cyc armed", bus.dpu_busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_dpu.md
# sram_dpu

Data processing unit paired with the UART-driven SRAM controller. It accepts a one-byte DPU command from the controller and exposes the target SRAM address. It captures the 32-bit word the controller reads from that address, applies a single-word operation, and presents the result for the controller's write-back. It sits beside the controller on the SRAM-side command path and never touches the SRAM directly.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, SRAM word address width
- INC_STEP, 1, addend used by the INC operation

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dpu_load_cmd  in  1  one-cycle command strobe from the controller
- nxt_cmd  in  8  command byte, valid with dpu_load_cmd: [7] must be 1; [6:5] opcode; [4:0] address
- requst_valid  in  1  controller strobe: first pulse = operand valid, second pulse = write-back commit
- sram_data_to_dpu  in  DATA_W  operand, valid with the first requst_valid
- sram_data_from_dpu  out  DATA_W  registered result
- sram_addr_from_dpu  out  ADDR_W  registered target address
- dpu_busy  out  1  high in any state other than D_IDLE
- dpu_done  out  1  one-cycle pulse after a commit
- dpu_err  out  1  sticky protocol-error flag

## Operation
- All outputs reset to 0. The state resets to D_IDLE, and cmd, operand, result and accumulator registers reset to 0.
- D_IDLE: on dpu_load_cmd with nxt_cmd[7]=1, latch the opcode and address, then go to D_ARMED. A strobe with nxt_cmd[7]=0 is ignored and raises no error.
- D_ARMED: on requst_valid, capture sram_data_to_dpu into the operand register, then go to D_CALC.
- D_CALC: unconditional single cycle. The result register loads alu(opcode, operand), then go to D_COMMIT.
- D_COMMIT: on requst_valid, go to D_IDLE and pulse dpu_done on the following cycle.
- Opcodes:
  - 00 INC: (operand + INC_STEP) mod 2^DATA_W
  - 01 NOT: bitwise inversion
  - 10 ROTL8: {operand[23:0], operand[31:24]}
  - 11: ACC, or PASS when the macro is absent (see Configuration)
- sram_addr_from_dpu and sram_data_from_dpu hold their last values in D_IDLE. They change only on a new command or a new result.
- Protocol errors set dpu_err, which is cleared only by reset. The errors are:
  - dpu_load_cmd with nxt_cmd[7]=1 while not in D_IDLE: the command is ignored.
  - requst_valid in D_IDLE or D_CALC: the strobe is ignored.
- dpu_load_cmd and requst_valid asserted in the same cycle in D_IDLE: the command is accepted, the requst_valid is treated as an error, and dpu_err is set.
- Reset mid-operation returns the block to D_IDLE immediately. Any pending result is discarded.

## Timing
Cycle T0 is the dpu_load_cmd cycle.
- Address valid from T1 and stable through the commit.
- Operand requst_valid arrives at T3 (earliest T1).
- Result valid from the cycle after D_CALC. In the nominal sequence that is T5, which is the controller's write-back cycle.
- Commit requst_valid arrives at T5, dpu_done is high at T6, and dpu_busy is low from T6.
- Minimum operand-to-result latency is 2 cycles. The block tolerates arbitrary gaps between strobes.

## Configuration
- DPU_ACC_EN defined: opcode 11 is ACC.
  - The accumulator updates as acc <= acc + operand (mod 2^DATA_W) in D_CALC.
  - The result is the new acc.
  - acc persists across commands and is cleared only by reset.
- DPU_ACC_EN undefined: opcode 11 is PASS (result = operand). No accumulator register is built.

## Structure
- Shared package sram_pkg holds:
  - the opcode constants OP_INC, OP_NOT, OP_ROTL8, OP_ACC
  - the state encoding D_IDLE, D_ARMED, D_CALC, D_COMMIT
  - the command-field bit positions
- One sub-module, sram_dpu_alu: combinational, taking opcode, operand and acc and producing the result. The sequencing and registers stay in sram_dpu.

## Test plan
- INC: cmd 0x83, operand 0x0000_00FF at T3, commit at T5 -> addr 3 from T1; result 0x0000_0100 at T5; dpu_done at T6.
- NOT with wrap: cmd 0xBF (opcode 01, addr 31), operand 0xA5A5_0000 -> result 0x5A5A_FFFF, addr 31. Then INC on operand 0xFFFF_FFFF -> result 0x0000_0000.
- ROTL8 then opcode 11:
  - ROTL8: operand 0x1122_3344 -> 0x2233_4411.
  - With DPU_ACC_EN: two 0xE0 commands with operands 5 then 7 -> results 5 then 12.
  - Without DPU_ACC_EN: the same two commands -> results 5 and 7.
- Protocol errors: requst_valid in D_IDLE -> dpu_err=1, state unchanged. A second 0x81 during D_ARMED -> ignored, address stays at the original value.
- Stalls: 10-cycle gaps before each requst_valid -> same results. dpu_busy stays high throughout, and dpu_done fires once.
- Reset mid-operation: assert rst_n=0 in D_COMMIT -> all outputs 0 asynchronously and state D_IDLE. A new command afterwards completes normally with dpu_err=0.
